alu_seq: RTL and testbench

- Issue/writeback sequencer sitting directly upstream and downstream of the combinational 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from a small internal register file.
- Drives the ALU's op/operand inputs, captures the ALU result after a settle cycle, and writes it back to the register file.
- Reports each completion as a one-cycle result pulse with an error flag.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, FSM encoding
// and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_ADD2    = 4'd1;
    localparam logic [3:0] OP_CMP     = 4'd5;
    localparam logic [3:0] OP_NOT     = 4'd7;
    localparam logic [3:0] OP_AND     = 4'd8;
    localparam logic [3:0] OP_OR      = 4'd10;
    localparam logic [3:0] OP_REGDEC  = 4'd14;
    localparam logic [3:0] OP_REGDEC2 = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_ADD2, OP_CMP, OP_NOT,
            OP_AND, OP_OR, OP_REGDEC, OP_REGDEC2: legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: NREG x W flops, one synchronous write port and two
// asynchronous read ports, cleared by synchronous reset.
module alu_regfile #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [W-1:0]  rdata2
);

    logic [W-1:0] regs [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : gen_reg
            logic [W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_seq.sv
// Issue/writeback sequencer around an external combinational ALU: accepts one
// instruction at a time, reads operands, captures the ALU result and writes it back.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          instr_ld,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic [W-1:0]  instr_imm,
    output logic [3:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_res,
    output logic          res_valid,
    output logic [W-1:0]  res_data,
    output logic          res_err
);

    state_t        state_reg, state_next;
    logic          accept;
    logic          rf_we;
    logic [3:0]    op_reg;
    logic [AW-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [3:0]    alu_op_reg;
    logic [W-1:0]  alu_a_reg, alu_b_reg;
    logic [W-1:0]  res_data_reg;
    logic          err_reg;
    logic [W-1:0]  rdata1, rdata2;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Loads and illegal opcodes skip the ALU entirely and complete next cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (instr_ld || !op_legal(instr_op)) begin
                        state_next = WB;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_reg == IDLE) && !reset;
        res_valid   = (state_reg == WB) && !reset;
        rf_we       = (state_reg == WB) && !reset && !err_reg;
    end

    // Operands are sampled in READ and written in WB, so aliased sources
    // always see pre-instruction values.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg       <= '0;
            rd_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            alu_op_reg   <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            res_data_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg  <= instr_op;
                        rd_reg  <= instr_rd;
                        rs1_reg <= instr_rs1;
                        rs2_reg <= instr_rs2;
                        if (instr_ld) begin
                            res_data_reg <= instr_imm;
                            err_reg      <= 1'b0;
                        end else if (!op_legal(instr_op)) begin
                            res_data_reg <= '0;
                            err_reg      <= 1'b1;
                        end else begin
                            err_reg      <= 1'b0;
                        end
                    end
                end
                READ: begin
                    alu_op_reg <= op_reg;
                    alu_a_reg  <= rdata1;
                    alu_b_reg  <= rdata2;
                end
                EXEC: begin
                    res_data_reg <= alu_res;
                end
                default: begin
                end
            endcase
        end
    end

    alu_regfile #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rd_reg),
        .wdata  (res_data_reg),
        .raddr1 (rs1_reg),
        .rdata1 (rdata1),
        .raddr2 (rs2_reg),
        .rdata2 (rdata2)
    );

    assign alu_op   = alu_op_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign res_data = res_data_reg;
    assign res_err  = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq: a driver issues instructions and queues
// expected completions from a register-array model; a monitor checks each res_valid.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       instr_ld = 1'b0;
    logic [3:0] instr_op = '0;
    logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic [7:0] instr_imm = '0;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         acc;
        logic       chk_alu;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   mdl [4];
    int   cyc = 0;
    int   last_acc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_seq #(.W(8), .NREG(4), .AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_ld    (instr_ld),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_res     (alu_res),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err)
    );

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_res = 8'h00;
        case (alu_op)
            4'd0, 4'd1:   alu_res = alu_a + alu_b;
            4'd5:         alu_res = {5'b0, alu_a < alu_b, alu_a == alu_b, alu_a > alu_b};
            4'd7:         alu_res = ~alu_a;
            4'd8:         alu_res = alu_a & alu_b;
            4'd10:        alu_res = alu_a | alu_b;
            4'd14, 4'd15: alu_res = alu_a - 8'd1;
            default:      alu_res = 8'h00;
        endcase
    end

    function automatic int ref_alu(input int op, input int x, input int y);
        case (op)
            0, 1:   return (x + y) % 256;
            5:      return (x > y ? 1 : 0) + (x == y ? 2 : 0) + (x < y ? 4 : 0);
            7:      return 255 - x;
            8:      return x & y;
            10:     return x | y;
            14, 15: return (x + 255) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input int op);
        return op inside {0, 1, 5, 7, 8, 10, 14, 15};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic ld, input int op, input int rd, input int rs1,
                         input int rs2, input int imm, input bit keep, input bit gap_chk);
        exp_t e;
        bit   accepted = 0;
        @(negedge clk);
        instr_ld    = ld;
        instr_op    = 4'(op);
        instr_rd    = 2'(rd);
        instr_rs1   = 2'(rs1);
        instr_rs2   = 2'(rs2);
        instr_imm   = 8'(imm);
        instr_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (instr_ready) begin
                e.acc = cyc;
                e.chk_alu = 1'b0;
                e.op = 4'(op);
                e.a = 8'h00;
                e.b = 8'h00;
                if (ld) begin
                    e.data = 8'(imm); e.err = 1'b0; e.lat = 1;
                    mdl[rd] = imm % 256;
                end else if (!is_legal(op)) begin
                    e.data = 8'h00; e.err = 1'b1; e.lat = 1;
                end else begin
                    e.data = 8'(ref_alu(op, mdl[rs1], mdl[rs2]));
                    e.err = 1'b0; e.lat = 3; e.chk_alu = 1'b1;
                    e.a = 8'(mdl[rs1]); e.b = 8'(mdl[rs2]);
                    mdl[rd] = ref_alu(op, mdl[rs1], mdl[rs2]);
                end
                sb.push_back(e);
                if (gap_chk) chk("issue_spacing", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: instr_ready never rose, expected acceptance");
            instr_valid = 1'b0;
        end else if (!keep) begin
            @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    task automatic readback(input int r);
        issue(1'b0, 10, r, r, r, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        repeat (ncyc) @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        reset = 1'b0;
        #1 chk("ready_after_reset", 32'(instr_ready), 32'd1);
    endtask

    // Scoreboard monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].acc < cyc) begin
                chk("busy_ready", 32'(instr_ready), 32'd0);
                if (!res_valid && (cyc - sb[0].acc) > 4) begin
                    n_checks++; n_fail++;
                    $display("FAIL res_timeout: no res_valid %0d cycles after accept, expected within 3",
                             cyc - sb[0].acc);
                    void'(sb.pop_front());
                end
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_res_valid: got res_valid=1 data=0x%0h, expected none", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_err", 32'(res_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    if (e.chk_alu) begin
                        chk("alu_op", 32'(alu_op), 32'(e.op));
                        chk("alu_a", 32'(alu_a), 32'(e.a));
                        chk("alu_b", 32'(alu_b), 32'(e.b));
                    end
                    n_txn++;
                    $display("txn %0d: op=%0d data=0x%02h err=%0b lat=%0d",
                             n_txn, e.op, res_data, res_err, cyc - e.acc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        do_reset(2);

        issue(1'b1, 0, 1, 0, 0, 8'h12, 1'b0, 1'b0);
        issue(1'b1, 0, 0, 0, 0, 8'hF0, 1'b0, 1'b0);
        issue(1'b1, 0, 1, 0, 0, 8'h20, 1'b0, 1'b0);
        issue(1'b0, 0, 2, 0, 1, 0, 1'b0, 1'b0);
        issue(1'b0, 12, 3, 1, 2, 0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) readback(r);

        issue(1'b1, 0, 3, 0, 0, 8'h55, 1'b0, 1'b0);
        issue(1'b0, 7, 3, 3, 1, 0, 1'b0, 1'b0);
        issue(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        issue(1'b1, 0, 0, 0, 0, 8'hA1, 1'b1, 1'b0);
        issue(1'b1, 0, 1, 0, 0, 8'hB2, 1'b1, 1'b1);
        issue(1'b1, 0, 2, 0, 0, 8'hC3, 1'b1, 1'b1);
        issue(1'b1, 0, 3, 0, 0, 8'hD4, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) readback(r);

        issue(1'b1, 0, 0, 0, 0, 8'h07, 1'b0, 1'b0);
        issue(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        do_reset(2);
        for (int r = 0; r < 4; r++) readback(r);

        for (int n = 0; n < 250; n++) begin
            issue(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), 1'b0);
        end
        for (int r = 0; r < 4; r++) readback(r);

        for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d completions outstanding, expected 0", sb.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
